// File: rtl/picosoc_mem_ctrl_pkg.sv
// Shared definitions for the picosoc SRAM front-end: FSM encodings and
// SRAM geometry constants.
package picosoc_mem_pkg;

   localparam int RAM_AW     = 22;
   localparam int WORD_BYTES = 4;
   localparam int WAIT_CNT_W = 3;

   localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
   localparam logic [2:0] ST_ACCESS_ENC = 3'd1;
   localparam logic [2:0] ST_WAIT_ENC   = 3'd2;
   localparam logic [2:0] ST_RESP_ENC   = 3'd3;
   localparam logic [2:0] ST_CLEAR_ENC  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_ACCESS = ST_ACCESS_ENC,
      ST_WAIT   = ST_WAIT_ENC,
      ST_RESP   = ST_RESP_ENC,
      ST_CLEAR  = ST_CLEAR_ENC
   } state_t;

endpackage

// File: rtl/picosoc_mem_ctrl.sv
// picosoc_mem_ctrl: bus slave that turns the CPU mem_valid/mem_ready handshake
// into single-cycle strobes for a byte-enabled, registered-read SRAM.
// Optional build macro PICOSOC_MEM_CTRL_CLEAR_EN: after reset the controller
// zero-fills the whole SRAM before accepting requests (init_done marks the end).
module picosoc_mem_ctrl
   import picosoc_mem_pkg::*;
#(
   parameter int          WORDS       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                mem_valid,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wdata,
   input  logic [3:0]          mem_wstrb,
   output logic                mem_ready,
   output logic [31:0]         mem_rdata,
   output logic [3:0]          ram_wen,
   output logic [RAM_AW-1:0]   ram_addr,
   output logic [31:0]         ram_wdata,
   input  logic [31:0]         ram_rdata,
   output logic                init_done
);

   localparam logic [31:0] WIN_BYTES = 32'(WORD_BYTES * WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   state_t                  state_q;
   logic [3:0]              ram_wen_q;
   logic [RAM_AW-1:0]       ram_addr_q;
   logic [31:0]             ram_wdata_q;
   logic                    ready_q;
   logic                    is_rd_q;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q;

   logic [31:0]             offs;
   logic                    hit;
   logic                    unused_offs_bits;

   // Window decode: unsigned wrap-around makes addresses below BASE_ADDR miss.
   assign offs             = mem_addr - BASE_ADDR;
   assign hit              = mem_valid && (offs < WIN_BYTES);
   assign unused_offs_bits = ^{offs[31:RAM_AW+2], offs[1:0]};

`ifdef PICOSOC_MEM_CTRL_CLEAR_EN
   localparam logic [RAM_AW-1:0] LAST_WORD = RAM_AW'(WORDS - 1);

   logic [RAM_AW-1:0]       clr_cnt_q;
   logic                    init_done_q;

   // Request FSM plus zero-fill sweep that runs after every reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         ram_wen_q   <= 4'h0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'h0;
         ready_q     <= 1'b0;
         is_rd_q     <= 1'b0;
         wait_cnt_q  <= '0;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         ready_q   <= 1'b0;
         ram_wen_q <= 4'h0;
         case (state_q)
            ST_CLEAR: begin
               if (clr_cnt_q == LAST_WORD) begin
                  state_q     <= ST_IDLE;
                  init_done_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (hit) begin
                  ram_addr_q  <= offs[RAM_AW+1:2];
                  ram_wdata_q <= mem_wdata;
                  ram_wen_q   <= mem_wstrb;
                  is_rd_q     <= (mem_wstrb == 4'h0);
                  state_q     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               wait_cnt_q <= WAIT_LOAD;
               if (WAIT_STATES > 0) begin
                  state_q <= ST_WAIT;
               end else begin
                  state_q <= ST_RESP;
                  ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_q == '0) begin
                  state_q <= ST_RESP;
                  ready_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // During the sweep the SRAM port is driven straight from the clear counter
   // so word 0 is written in the first cycle after reset.
   assign ram_wen   = (state_q == ST_CLEAR) ? 4'hF      : ram_wen_q;
   assign ram_addr  = (state_q == ST_CLEAR) ? clr_cnt_q : ram_addr_q;
   assign ram_wdata = (state_q == ST_CLEAR) ? 32'h0     : ram_wdata_q;
   assign init_done = init_done_q;
`else
   // Request FSM: accept in IDLE, strobe SRAM in ACCESS, optional WAIT, respond in RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ram_wen_q   <= 4'h0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'h0;
         ready_q     <= 1'b0;
         is_rd_q     <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         ready_q   <= 1'b0;
         ram_wen_q <= 4'h0;
         case (state_q)
            ST_IDLE: begin
               if (hit) begin
                  ram_addr_q  <= offs[RAM_AW+1:2];
                  ram_wdata_q <= mem_wdata;
                  ram_wen_q   <= mem_wstrb;
                  is_rd_q     <= (mem_wstrb == 4'h0);
                  state_q     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               wait_cnt_q <= WAIT_LOAD;
               if (WAIT_STATES > 0) begin
                  state_q <= ST_WAIT;
               end else begin
                  state_q <= ST_RESP;
                  ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_q == '0) begin
                  state_q <= ST_RESP;
                  ready_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ram_wen   = ram_wen_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign init_done = 1'b1;
`endif

   // Response: ready only in RESP; read data gated so other slaves can be ORed/muxed.
   assign mem_ready = ready_q;
   assign mem_rdata = (ready_q && is_rd_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_picosoc_mem_ctrl.sv
// Directed bench for picosoc_mem_ctrl: four instances with different
// parameters, each backed by a byte-enabled registered-read SRAM model.
module tb_picosoc_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        vld  [4];
   logic [31:0] addr [4];
   logic [31:0] wdat [4];
   logic [3:0]  strb [4];
   logic [31:0] rrd  [4];

   logic        rdy0, rdy1, rdy2, rdy3;
   logic [31:0] rdat0, rdat1, rdat2, rdat3;
   logic [3:0]  wen0, wen1, wen2, wen3;
   logic [21:0] rad0, rad1, rad2, rad3;
   logic [31:0] rwd0, rwd1, rwd2, rwd3;
   logic        idn0, idn1, idn2, idn3;

   logic        rdy_a   [4];
   logic [31:0] rdat_a  [4];
   logic [3:0]  wen_a   [4];
   logic [21:0] raddr_a [4];
   logic [31:0] rwd_a   [4];
   logic        idone_a [4];

   logic [31:0] mem [4][256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // u0: base 0, no wait states
   picosoc_mem_ctrl #(.WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
      .clk(clk), .reset(reset), .mem_valid(vld[0]), .mem_addr(addr[0]),
      .mem_wdata(wdat[0]), .mem_wstrb(strb[0]), .mem_ready(rdy0), .mem_rdata(rdat0),
      .ram_wen(wen0), .ram_addr(rad0), .ram_wdata(rwd0), .ram_rdata(rrd[0]),
      .init_done(idn0));

   // u1: three wait states
   picosoc_mem_ctrl #(.WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u1 (
      .clk(clk), .reset(reset), .mem_valid(vld[1]), .mem_addr(addr[1]),
      .mem_wdata(wdat[1]), .mem_wstrb(strb[1]), .mem_ready(rdy1), .mem_rdata(rdat1),
      .ram_wen(wen1), .ram_addr(rad1), .ram_wdata(rwd1), .ram_rdata(rrd[1]),
      .init_done(idn1));

   // u2: window at 0x0001_0000
   picosoc_mem_ctrl #(.WORDS(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) u2 (
      .clk(clk), .reset(reset), .mem_valid(vld[2]), .mem_addr(addr[2]),
      .mem_wdata(wdat[2]), .mem_wstrb(strb[2]), .mem_ready(rdy2), .mem_rdata(rdat2),
      .ram_wen(wen2), .ram_addr(rad2), .ram_wdata(rwd2), .ram_rdata(rrd[2]),
      .init_done(idn2));

   // u3: 16-word SRAM for the clear sweep
   picosoc_mem_ctrl #(.WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u3 (
      .clk(clk), .reset(reset), .mem_valid(vld[3]), .mem_addr(addr[3]),
      .mem_wdata(wdat[3]), .mem_wstrb(strb[3]), .mem_ready(rdy3), .mem_rdata(rdat3),
      .ram_wen(wen3), .ram_addr(rad3), .ram_wdata(rwd3), .ram_rdata(rrd[3]),
      .init_done(idn3));

   always_comb begin
      rdy_a[0] = rdy0;  rdy_a[1] = rdy1;  rdy_a[2] = rdy2;  rdy_a[3] = rdy3;
      rdat_a[0] = rdat0; rdat_a[1] = rdat1; rdat_a[2] = rdat2; rdat_a[3] = rdat3;
      wen_a[0] = wen0;  wen_a[1] = wen1;  wen_a[2] = wen2;  wen_a[3] = wen3;
      raddr_a[0] = rad0; raddr_a[1] = rad1; raddr_a[2] = rad2; raddr_a[3] = rad3;
      rwd_a[0] = rwd0;  rwd_a[1] = rwd1;  rwd_a[2] = rwd2;  rwd_a[3] = rwd3;
      idone_a[0] = idn0; idone_a[1] = idn1; idone_a[2] = idn2; idone_a[3] = idn3;
   end

   // SRAM model: byte writes and a registered read (old data on a same-edge write)
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 4; b++)
            if (wen_a[k][b]) mem[k][raddr_a[k][7:0]][8*b +: 8] <= rwd_a[k][8*b +: 8];
         rrd[k] <= mem[k][raddr_a[k][7:0]];
      end
   end

   task automatic wait_init();
`ifdef PICOSOC_MEM_CTRL_CLEAR_EN
      int n;
      n = 0;
      while (!(idone_a[0] && idone_a[1] && idone_a[2] && idone_a[3]) && n < 400) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL init_done_timeout got %0d cycles want < 400", n);
      end
`endif
   endtask

   // Leaves the bench 1 time unit after a rising edge with reset released.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // One CPU transaction on instance k; records latency, SRAM strobes and stray rdata.
   task automatic txn(input int k, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output int lat,
                      output int wen_cyc, output logic [3:0] wen_v,
                      output logic [21:0] wen_ad, output int bad_rd);
      bit got;
      got = 1'b0; rd = 32'h0; lat = 0; wen_cyc = 0; wen_v = 4'h0; wen_ad = '0; bad_rd = 0;
      vld[k] = 1'b1; addr[k] = a; wdat[k] = wd; strb[k] = st;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (wen_a[k] != 4'h0) begin
            wen_cyc++; wen_v = wen_a[k]; wen_ad = raddr_a[k];
         end
         if (rdy_a[k]) begin
            rd = rdat_a[k]; got = 1'b1;
            break;
         end
         if (rdat_a[k] != 32'h0) bad_rd++;
         lat++;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL txn_timeout inst %0d addr %h got no ready want ready", k, a);
      end
      @(posedge clk); #1;
      vld[k] = 1'b0; strb[k] = 4'h0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdy_a[k] !== 1'b0) begin errors++; $display("FAIL rst_ready inst %0d got %b want 0", k, rdy_a[k]); end
         checks++;
         if (rdat_a[k] !== 32'h0) begin errors++; $display("FAIL rst_rdata inst %0d got %h want 0", k, rdat_a[k]); end
`ifndef PICOSOC_MEM_CTRL_CLEAR_EN
         checks++;
         if (wen_a[k] !== 4'h0 || raddr_a[k] !== 22'h0 || rwd_a[k] !== 32'h0) begin
            errors++;
            $display("FAIL rst_ram inst %0d got wen %h addr %h wdata %h want 0 0 0", k, wen_a[k], raddr_a[k], rwd_a[k]);
         end
         checks++;
         if (idone_a[k] !== 1'b1) begin errors++; $display("FAIL rst_init_done inst %0d got %b want 1", k, idone_a[k]); end
`else
         checks++;
         if (idone_a[k] !== 1'b0) begin errors++; $display("FAIL rst_init_done inst %0d got %b want 0", k, idone_a[k]); end
`endif
      end
      @(posedge clk); #1;
      wait_init();
   endtask

   task automatic test_write_read();
      logic [31:0] rd; int lat, wc, bad; logic [3:0] wv; logic [21:0] wa;
      txn(0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, wc, wv, wa, bad);
      checks++;
      if (wc !== 1 || wv !== 4'hF || wa !== 22'd4) begin
         errors++;
         $display("FAIL wr_strobe got cycles %0d wen %h addr %0d want 1 F 4", wc, wv, wa);
      end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", rd); end
      txn(0, 32'h10, 32'h0, 4'h0, rd, lat, wc, wv, wa, bad);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want DEADBEEF", rd); end
      checks++;
      if (wc !== 0) begin errors++; $display("FAIL rd_no_wen got %0d want 0", wc); end
   endtask

   task automatic test_partial();
      logic [31:0] rd; int lat, wc, bad; logic [3:0] wv; logic [21:0] wa;
      txn(0, 32'h20, 32'h11223344, 4'hF, rd, lat, wc, wv, wa, bad);
      txn(0, 32'h22, 32'h0000AA00, 4'h2, rd, lat, wc, wv, wa, bad);
      checks++;
      if (wv !== 4'h2 || wa !== 22'd8) begin
         errors++;
         $display("FAIL part_strobe got wen %h addr %0d want 2 8", wv, wa);
      end
      txn(0, 32'h20, 32'h0, 4'h0, rd, lat, wc, wv, wa, bad);
      checks++;
      if (rd !== 32'h1122AA44) begin errors++; $display("FAIL part_data got %h want 1122AA44", rd); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; int lat, wc, bad; logic [3:0] wv; logic [21:0] wa;
      txn(1, 32'h40, 32'hCAFEF00D, 4'hF, rd, lat, wc, wv, wa, bad);
      checks++;
      if (lat !== 5 || wc !== 1) begin
         errors++;
         $display("FAIL ws_write got lat %0d wen cycles %0d want 5 1", lat, wc);
      end
      txn(1, 32'h40, 32'h0, 4'h0, rd, lat, wc, wv, wa, bad);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL ws_latency got %0d want 5", lat); end
      checks++;
      if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_data got %h want CAFEF00D", rd); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL ws_stray_rdata got %0d cycles want 0", bad); end
      @(negedge clk);
      checks++;
      if (rdy_a[1] !== 1'b0 || rdat_a[1] !== 32'h0) begin
         errors++;
         $display("FAIL ws_pulse_width got ready %b rdata %h want 0 0", rdy_a[1], rdat_a[1]);
      end
      @(posedge clk); #1;
   endtask

   task automatic probe_miss(input logic [31:0] a);
      int nr, nw;
      nr = 0; nw = 0;
      vld[2] = 1'b1; addr[2] = a; wdat[2] = 32'h5555AAAA; strb[2] = 4'hF;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rdy_a[2]) nr++;
         if (wen_a[2] != 4'h0) nw++;
      end
      @(posedge clk); #1;
      vld[2] = 1'b0; strb[2] = 4'h0;
      checks++;
      if (nr !== 0 || nw !== 0) begin
         errors++;
         $display("FAIL miss_%h got ready %0d wen %0d cycles want 0 0", a, nr, nw);
      end
   endtask

   task automatic test_window();
      logic [31:0] rd; int lat, wc, bad; logic [3:0] wv; logic [21:0] wa;
      probe_miss(32'h0001_0400);
      probe_miss(32'h0000_FFFC);
      txn(2, 32'h0001_03FC, 32'h5A5A1234, 4'hF, rd, lat, wc, wv, wa, bad);
      checks++;
      if (wa !== 22'd255 || wc !== 1 || lat !== 2) begin
         errors++;
         $display("FAIL win_top got addr %0d wen cycles %0d lat %0d want 255 1 2", wa, wc, lat);
      end
      txn(2, 32'h0001_03FC, 32'h0, 4'h0, rd, lat, wc, wv, wa, bad);
      checks++;
      if (rd !== 32'h5A5A1234) begin errors++; $display("FAIL win_read got %h want 5A5A1234", rd); end
   endtask

   task automatic test_reset_access();
      logic [31:0] rd; int lat, wc, bad, nr; logic [3:0] wv; logic [21:0] wa;
      vld[0] = 1'b1; addr[0] = 32'h80; wdat[0] = 32'h0BADF00D; strb[0] = 4'hF;
      @(posedge clk); #1;
      reset = 1'b1; vld[0] = 1'b0; strb[0] = 4'h0;
      @(negedge clk);
      checks++;
      if (wen_a[0] !== 4'hF || raddr_a[0] !== 22'd32) begin
         errors++;
         $display("FAIL ra_access got wen %h addr %0d want F 32", wen_a[0], raddr_a[0]);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy_a[0] !== 1'b0 || rdat_a[0] !== 32'h0) begin
         errors++;
         $display("FAIL ra_outputs got ready %b rdata %h want 0 0", rdy_a[0], rdat_a[0]);
      end
`ifndef PICOSOC_MEM_CTRL_CLEAR_EN
      checks++;
      if (wen_a[0] !== 4'h0 || raddr_a[0] !== 22'h0 || rwd_a[0] !== 32'h0) begin
         errors++;
         $display("FAIL ra_ram got wen %h addr %h wdata %h want 0 0 0", wen_a[0], raddr_a[0], rwd_a[0]);
      end
`endif
      nr = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rdy_a[0]) nr++;
      end
      checks++;
      if (nr !== 0) begin errors++; $display("FAIL ra_no_ready got %0d pulses want 0", nr); end
      @(posedge clk); #1;
      wait_init();
      txn(0, 32'h80, 32'h0, 4'h0, rd, lat, wc, wv, wa, bad);
      checks++;
`ifdef PICOSOC_MEM_CTRL_CLEAR_EN
      if (rd !== 32'h0) begin errors++; $display("FAIL ra_readback got %h want 0", rd); end
`else
      if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL ra_readback got %h want 0BADF00D", rd); end
`endif
   endtask

`ifdef PICOSOC_MEM_CTRL_CLEAR_EN
   task automatic test_clear();
      logic [31:0] rd; int lat, wc, bad, lo, early; bit got;
      logic [3:0] wv; logic [21:0] wa;
      txn(3, 32'hC, 32'h12345678, 4'hF, rd, lat, wc, wv, wa, bad);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vld[3] = 1'b1; addr[3] = 32'hC; strb[3] = 4'h0;
      lo = 0; early = 0; got = 1'b0; rd = 32'hFFFF_FFFF;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!idone_a[3]) lo++;
         if (rdy_a[3]) begin
            if (!idone_a[3]) early++;
            rd = rdat_a[3]; got = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      vld[3] = 1'b0;
      checks++;
      if (lo !== 16) begin errors++; $display("FAIL clr_init_low got %0d want 16", lo); end
      checks++;
      if (!got || early !== 0) begin
         errors++;
         $display("FAIL clr_ready got done %0d early %0d want 1 0", got, early);
      end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL clr_data got %h want 0", rd); end
      wait_init();
   endtask
`endif

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0; addr[k] = 32'h0; wdat[k] = 32'h0; strb[k] = 4'h0;
      end
      @(posedge clk); #1;
      test_reset();
      test_write_read();
      test_partial();
      test_wait_states();
      test_window();
      test_reset_access();
`ifdef PICOSOC_MEM_CTRL_CLEAR_EN
      test_clear();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/picosoc_mem_ctrl.md
Name: picosoc_mem_ctrl

Overview:
- Bus slave front-end that sits directly upstream of the single-port byte-enabled SoC SRAM (1-cycle registered read, byte write enables, word address).
- Converts the CPU native memory handshake (mem_valid/mem_ready) into single-cycle SRAM strobes.
- Decodes its address window, inserts programmable wait states and returns one mem_ready pulse per hit.
- The SoC top ORs mem_ready and muxes mem_rdata with the other slaves.

Parameters:
- WORDS, 256, SRAM depth in 32-bit words; the window spans 4*WORDS bytes.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be 4*WORDS aligned.
- WAIT_STATES, 0, extra cycles (0..7) inserted between the SRAM access and the response.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  CPU request valid
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 means read
- mem_ready  out  1  one-cycle response pulse, this slave only
- mem_rdata  out  32  read data, valid only while mem_ready=1
- ram_wen  out  4  SRAM byte write enables
- ram_addr  out  22  SRAM word address
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM registered read data
- init_done  out  1  high once the block accepts requests

Behaviour:
- hit = mem_valid && (mem_addr - BASE_ADDR) < 4*WORDS, using unsigned 32-bit subtraction.
- ram_addr = (mem_addr - BASE_ADDR) >> 2, zero-extended to 22 bits.
- FSM states: IDLE, ACCESS, WAIT, RESP, plus CLEAR when the optional feature is compiled in. State is registered.
- IDLE:
  - On hit: register ram_addr, ram_wdata, ram_wen=mem_wstrb and a flag is_rd=(mem_wstrb==0), then go to ACCESS.
  - Non-hit requests are ignored and the FSM stays in IDLE.
- ACCESS: ram_wen=0 on the next edge. Go to WAIT if WAIT_STATES>0, else RESP. Load the wait counter with WAIT_STATES-1.
- WAIT: decrement the counter; at 0 go to RESP.
- RESP:
  - mem_ready=1 for exactly this cycle.
  - mem_rdata = is_rd ? ram_rdata : 32'h0, driven combinationally from registered state.
  - Go to IDLE.
- Latency: request first seen in cycle n → mem_ready in cycle n+2+WAIT_STATES. Back-to-back requests need no idle cycle beyond the IDLE acceptance cycle.
- Write enables:
  - ram_wen is asserted for exactly one cycle (ACCESS) per write. Partial strobes are passed through unchanged.
  - ram_addr and ram_wdata are held stable from ACCESS through RESP, because the SRAM re-reads every cycle.
- Outputs outside RESP: mem_ready=0 and mem_rdata=0.
- mem_valid dropping mid-transaction is illegal. The transaction still completes and mem_ready still pulses.
- Reset values: state IDLE (or CLEAR), ram_wen=0, ram_addr=0, ram_wdata=0, mem_ready=0, counter 0.
- Reset during ACCESS: the SRAM write strobed in that cycle still lands, but no response is issued.
- Read of a location written by the immediately preceding transaction returns the new data. The write committed at its ACCESS edge, before the read's ACCESS.

Optional Feature:
- Macro: PICOSOC_MEM_CTRL_CLEAR_EN.
- Defined:
  - After reset the FSM enters CLEAR and writes 32'h0 with ram_wen=4'hF to words 0..WORDS-1, one word per cycle.
  - init_done=0 during the sweep and rises the cycle after word WORDS-1 is written; the FSM then enters IDLE.
  - Requests during CLEAR are not accepted; mem_ready stays 0 and the CPU stalls.
  - Reset mid-sweep restarts the sweep from word 0.
- Undefined: init_done is tied to 1 and reset enters IDLE.

Decomposition:
- Package picosoc_mem_pkg holds:
  - FSM state encodings (3-bit localparams);
  - RAM_AW=22;
  - WORD_BYTES=4;
  - WAIT_CNT_W=3.
- No sub-module. The wait counter and clear counter are a few lines of inline logic in picosoc_mem_ctrl.

Test Plan:
- Reset, WAIT_STATES=0, write addr 0x10 wdata 0xDEADBEEF wstrb 0xF, then read 0x10 → ram_wen=0xF for one cycle at ram_addr 4; read's mem_ready 2 cycles after valid; mem_rdata=0xDEADBEEF.
- Write wstrb 0x2 wdata 0x0000AA00 to word holding 0x11223344, read back → mem_rdata=0x1122AA44.
- WAIT_STATES=3, read → mem_ready exactly 5 cycles after mem_valid; pulse 1 cycle wide; mem_rdata=0 in all other cycles.
- BASE_ADDR=0x0001_0000, WORDS=256, valid at 0x0001_0400 and 0x0000_FFFC → no mem_ready, ram_wen stays 0; access at 0x0001_03FC hits ram_addr 255.
- Assert reset in the ACCESS cycle of a write → no mem_ready; a later read of that word returns the written data; all outputs at reset values.
- With PICOSOC_MEM_CTRL_CLEAR_EN, WORDS=16: init_done low for 16 cycles after reset; a read issued during the sweep completes only after init_done rises and returns 0.
